binaryzation_local: RTL and testbench

BINARYZATION_LOCAL -- requirements
Module: binaryzation_local

---
 rtl/binaryzation_local_pkg.sv | 20 ++
 rtl/binaryzation_win_buf.sv | 36 +++
 rtl/binaryzation_local.sv | 146 ++++++++++++++
 tb/tb_binaryzation_local.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/binaryzation_local_pkg.sv
// Shared definitions for the local-mean binaryzation block.
// Holds the mode encoding and small helpers that decode it.
package binaryzation_local_pkg;

  typedef enum logic [1:0] {
    MODE_GLOBAL     = 2'd0,
    MODE_GLOBAL_INV = 2'd1,
    MODE_LOCAL      = 2'd2,
    MODE_LOCAL_INV  = 2'd3
  } mode_e;

  function automatic logic mode_is_local(input mode_e m);
    return (m == MODE_LOCAL) || (m == MODE_LOCAL_INV);
  endfunction

  function automatic logic mode_is_inverted(input mode_e m);
    return (m == MODE_GLOBAL_INV) || (m == MODE_LOCAL_INV);
  endfunction

endpackage

// File: rtl/binaryzation_win_buf.sv
// W-entry circular delay buffer for the local window.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (pointer only)
//   wr_en        : push wr_data into the buffer
//   wr_data      : sample to store
//   rd_oldest    : entry about to be overwritten, i.e. the sample written
//                  W pushes ago (only meaningful once W samples were written)
module binaryzation_win_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_LOG2   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_oldest
);

  localparam int W = 1 << WIN_LOG2;

  logic [DATA_WIDTH-1:0] mem [W];
  logic [WIN_LOG2-1:0]   ptr_q;

  // Contents are not reset: the caller masks them with its fill count.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      ptr_q <= '0;
    else if (wr_en) ptr_q <= ptr_q + 1'b1;
  end

  assign rd_oldest = mem[ptr_q];

endmodule

// File: rtl/binaryzation_local.sv
// Pixel binaryzation against a global threshold or a local running mean.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   pixel_datav_i          : pixel valid
//   pixel_sol_i            : start of line (qualified by pixel_datav_i)
//   pixel_data_i           : unsigned pixel
//   threshold_i            : global threshold, captured at SOL
//   offset_i               : signed offset on the local mean, captured at SOL
//   mode_i                 : mode, captured at SOL
//   binaryzation_datav_o   : result valid, 2 clocks after pixel_datav_i
//   binaryzation_data_o    : all-ones or all-zeros result
module binaryzation_local
  import binaryzation_local_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_LOG2   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pixel_datav_i,
  input  logic                  pixel_sol_i,
  input  logic [DATA_WIDTH-1:0] pixel_data_i,
  input  logic [DATA_WIDTH-1:0] threshold_i,
  input  logic [DATA_WIDTH:0]   offset_i,
  input  logic [1:0]            mode_i,
  output logic                  binaryzation_datav_o,
  output logic [DATA_WIDTH-1:0] binaryzation_data_o
);

  localparam int SUM_W = DATA_WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_FULL = {1'b1, {WIN_LOG2{1'b0}}};

  // Settings captured at SOL
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [DATA_WIDTH:0]   off_q;

  // Window state
  logic [SUM_W-1:0]      sum_q;
  logic [WIN_LOG2:0]     fill_q;
  logic [DATA_WIDTH-1:0] oldest;

  // Stage 1
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_pixel_q;
  logic [DATA_WIDTH-1:0] s1_thr_q;
  logic                  s1_inv_q;

  // Effective values for the current pixel: an SOL pixel sees the new
  // settings and an empty window, so both are muxed before classification.
  mode_e                 mode_eff;
  logic [DATA_WIDTH-1:0] thr_eff;
  logic [DATA_WIDTH:0]   off_eff;
  logic [SUM_W-1:0]      sum_eff;
  logic [WIN_LOG2:0]     fill_eff;
  logic                  full;
  logic [DATA_WIDTH-1:0] mean;
  logic [DATA_WIDTH+1:0] local_raw;
  logic [DATA_WIDTH-1:0] local_thr;
  logic [DATA_WIDTH-1:0] sel_thr;
  logic [SUM_W-1:0]      sum_next;
  logic [WIN_LOG2:0]     fill_next;

  always_comb begin
    mode_eff  = pixel_sol_i ? mode_e'(mode_i) : mode_q;
    thr_eff   = pixel_sol_i ? threshold_i : thr_q;
    off_eff   = pixel_sol_i ? offset_i : off_q;
    sum_eff   = pixel_sol_i ? '0 : sum_q;
    fill_eff  = pixel_sol_i ? '0 : fill_q;
    full      = (fill_eff == FILL_FULL);

    mean      = sum_eff[SUM_W-1:WIN_LOG2];
    // Two extra bits hold the full signed range of mean + offset.
    local_raw = DATA_WIDTH'(0) + ({2'b00, mean} + {off_eff[DATA_WIDTH], off_eff});
    if (local_raw[DATA_WIDTH+1])  local_thr = '0;
    else if (local_raw[DATA_WIDTH]) local_thr = '1;
    else                           local_thr = local_raw[DATA_WIDTH-1:0];

    sel_thr   = (mode_is_local(mode_eff) && full) ? local_thr : thr_eff;

    sum_next  = sum_eff + {{WIN_LOG2{1'b0}}, pixel_data_i}
              - (full ? {{WIN_LOG2{1'b0}}, oldest} : '0);
    fill_next = full ? fill_eff : fill_eff + 1'b1;
  end

  binaryzation_win_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_LOG2  (WIN_LOG2)
  ) u_win_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (pixel_datav_i),
    .wr_data  (pixel_data_i),
    .rd_oldest(oldest)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= MODE_GLOBAL;
      thr_q  <= '0;
      off_q  <= '0;
    end else if (pixel_datav_i && pixel_sol_i) begin
      mode_q <= mode_e'(mode_i);
      thr_q  <= threshold_i;
      off_q  <= offset_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      fill_q <= '0;
    end else if (pixel_datav_i) begin
      sum_q  <= sum_next;
      fill_q <= fill_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_pixel_q <= '0;
      s1_thr_q   <= '0;
      s1_inv_q   <= 1'b0;
    end else begin
      s1_valid_q <= pixel_datav_i;
      if (pixel_datav_i) begin
        s1_pixel_q <= pixel_data_i;
        s1_thr_q   <= sel_thr;
        s1_inv_q   <= mode_is_inverted(mode_eff);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      binaryzation_datav_o <= 1'b0;
      binaryzation_data_o  <= '0;
    end else begin
      binaryzation_datav_o <= s1_valid_q;
      if (s1_valid_q)
        binaryzation_data_o <= {DATA_WIDTH{(s1_pixel_q > s1_thr_q) ^ s1_inv_q}};
    end
  end

endmodule

// File: tb/tb_binaryzation_local.sv
module tb_binaryzation_local;

  localparam int DW   = 8;
  localparam int WL   = 4;
  localparam int W    = 1 << WL;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          pixel_datav_i = 1'b0;
  logic          pixel_sol_i = 1'b0;
  logic [DW-1:0] pixel_data_i = '0;
  logic [DW-1:0] threshold_i = '0;
  logic [DW:0]   offset_i = '0;
  logic [1:0]    mode_i = '0;
  logic          binaryzation_datav_o;
  logic [DW-1:0] binaryzation_data_o;

  binaryzation_local #(.DATA_WIDTH(DW), .WIN_LOG2(WL)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .pixel_datav_i       (pixel_datav_i),
    .pixel_sol_i         (pixel_sol_i),
    .pixel_data_i        (pixel_data_i),
    .threshold_i         (threshold_i),
    .offset_i            (offset_i),
    .mode_i              (mode_i),
    .binaryzation_datav_o(binaryzation_datav_o),
    .binaryzation_data_o (binaryzation_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int exp_q[$];
  int due_q[$];

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: settings and the per-line window as a plain queue.
  int m_mode = 0, m_thr = 0, m_off = 0;
  int win[$];

  task automatic model_reset();
    m_mode = 0; m_thr = 0; m_off = 0;
    win.delete();
  endtask

  function automatic int model(input bit sol, input int pix, input int thr,
                               input int off, input int mode);
    int t, s, b;
    if (sol) begin
      m_mode = mode; m_thr = thr; m_off = off;
      win.delete();
    end
    t = m_thr;
    if (m_mode >= 2 && win.size() == W) begin
      s = 0;
      foreach (win[i]) s += win[i];
      t = s / W + m_off;
      if (t < 0) t = 0;
      if (t > MAXV) t = MAXV;
    end
    b = (pix > t) ? 1 : 0;
    if (m_mode % 2 == 1) b = 1 - b;
    win.push_back(pix);
    if (win.size() > W) void'(win.pop_front());
    return (b == 1) ? MAXV : 0;
  endfunction

  // Output monitor
  always @(negedge clk_i) begin
    if (!rst_i && binaryzation_datav_o) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("data", int'(binaryzation_data_o), exp_q.pop_front());
        chk("latency_cycle", cyc, due_q.pop_front());
      end
    end
  end

  // Drive one valid pixel; use_exp selects a literal expectation over the model.
  task automatic send(input bit sol, input int pix, input int thr, input int off,
                      input int mode, input bit use_exp, input int exp_v);
    int m;
    @(negedge clk_i);
    pixel_datav_i = 1'b1;
    pixel_sol_i   = sol;
    pixel_data_i  = pix[DW-1:0];
    threshold_i   = thr[DW-1:0];
    offset_i      = off[DW:0];
    mode_i        = mode[1:0];
    m = model(sol, pix, thr, off, mode);
    exp_q.push_back(use_exp ? exp_v : m);
    due_q.push_back(cyc + 2);
    n_in++;
  endtask

  // Idle cycles carry garbage, including stray SOL, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      pixel_datav_i = 1'b0;
      pixel_sol_i   = 1'($urandom_range(0, 1));
      pixel_data_i  = DW'($urandom);
      threshold_i   = DW'($urandom);
      offset_i      = (DW+1)'($urandom);
      mode_i        = 2'($urandom);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    idle(1);
    while (exp_q.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_count"}, n_out, n_in);
  endtask

  task automatic line_of(input int n, input int pix, input int thr, input int off,
                         input int mode, input int exp_v);
    for (int i = 0; i < n; i++) send(i == 0, pix, thr, off, mode, 1'b1, exp_v);
  endtask

  typedef struct {
    bit sol;
    int pix;
    int thr;
    int off;
    int mode;
    int exp_v;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{0, 0,   200, 0, 1, 0});    // pre-SOL: mode 0, threshold 0
    tbl.push_back('{0, 5,   200, 0, 1, MAXV});
    tbl.push_back('{1, 99,  100, 0, 0, 0});
    tbl.push_back('{0, 100, 100, 0, 0, 0});
    tbl.push_back('{0, 101, 100, 0, 0, MAXV});
    tbl.push_back('{0, 150, 200, 0, 0, MAXV}); // mid-line threshold change ignored
    tbl.push_back('{1, 99,  100, 0, 1, MAXV});
    tbl.push_back('{0, 100, 100, 0, 1, MAXV});
    tbl.push_back('{0, 101, 100, 0, 1, 0});
    tbl.push_back('{1, 0,   0,   0, 0, 0});
    tbl.push_back('{0, 1,   0,   0, 0, MAXV});
    tbl.push_back('{1, 255, 255, 0, 0, 0});
    tbl.push_back('{1, 255, 254, 0, 2, MAXV}); // local mode, empty window falls back

    model_reset();
    repeat (3) @(negedge clk_i);
    chk("reset_datav", int'(binaryzation_datav_o), 0);
    chk("reset_data", int'(binaryzation_data_o), 0);
    rst_i = 1'b0;
    idle(2);

    foreach (tbl[i]) send(tbl[i].sol, tbl[i].pix, tbl[i].thr, tbl[i].off,
                          tbl[i].mode, 1'b1, tbl[i].exp_v);
    drain("table");

    // Mean of 50 after a full window; fallback threshold before that.
    line_of(16, 50, 200, 0, 2, 0);
    send(0, 51, 200, 0, 2, 1'b1, MAXV);
    send(0, 50, 200, 0, 2, 1'b1, 0);
    // Offset -10 on a window of 60.
    line_of(16, 60, 200, -10, 2, 0);
    send(0, 55, 200, -10, 2, 1'b1, MAXV);
    send(0, 49, 200, -10, 2, 1'b1, 0);
    // Large positive offset saturates at the top.
    line_of(16, 60, 200, 255, 2, 0);
    send(0, 255, 200, 255, 2, 1'b1, 0);
    send(0, 255, 200, 255, 2, 1'b1, 0);
    // Large negative offset saturates at zero.
    line_of(16, 60, 0, -256, 2, MAXV);
    send(0, 0, 0, -256, 2, 1'b1, 0);
    send(0, 1, 0, -256, 2, 1'b1, MAXV);
    // Inverted local mode, and back-to-back short lines.
    line_of(16, 60, 200, 0, 3, MAXV);
    send(0, 61, 200, 0, 3, 1'b1, 0);
    line_of(3, 200, 100, -200, 2, MAXV);
    line_of(1, 10, 5, 0, 2, MAXV);
    line_of(2, 10, 50, 0, 3, MAXV);
    drain("directed");

    // Random lines with gaps; a new SOL lands mid-line whenever a line ends.
    for (int l = 0; l < 8; l++) begin
      int mode, thr, off, len;
      mode = $urandom_range(0, 3);
      thr  = $urandom_range(0, MAXV);
      off  = $urandom_range(0, 2 * MAXV + 1) - (MAXV + 1);
      len  = (l % 3 == 0) ? $urandom_range(1, W - 1) : $urandom_range(W + 1, 3 * W);
      for (int p = 0; p < len; p++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send(p == 0, $urandom_range(0, MAXV), $urandom_range(0, MAXV),
             $urandom_range(0, 2 * MAXV + 1) - (MAXV + 1), $urandom_range(0, 3),
             1'b0, 0);
        if (p == 0) begin
          // Overwrite the random settings on the SOL beat with this line's ones.
          void'(exp_q.pop_back());
          void'(due_q.pop_back());
          n_in--;
          win.delete();
          threshold_i = thr[DW-1:0];
          offset_i    = off[DW:0];
          mode_i      = mode[1:0];
          exp_q.push_back(model(1'b1, int'(pixel_data_i), thr, off, mode));
          due_q.push_back(cyc + 2);
          n_in++;
        end
      end
    end
    drain("random");

    // Reset in the middle of a line with outputs in flight.
    line_of(4, 200, 0, 0, 0, MAXV);
    @(negedge clk_i);
    pixel_datav_i = 1'b1;
    pixel_sol_i   = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midreset_datav", int'(binaryzation_datav_o), 0);
    chk("midreset_data", int'(binaryzation_data_o), 0);
    exp_q.delete();
    due_q.delete();
    n_in = 0;
    n_out = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    pixel_datav_i = 1'b0;
    rst_i = 1'b0;
    idle(4);
    chk("post_reset_no_valid", n_out, 0);
    send(0, 1, 200, 0, 3, 1'b1, MAXV); // settings back to mode 0, threshold 0
    line_of(16, 50, 200, 0, 2, 0);
    send(0, 51, 200, 0, 2, 1'b1, MAXV);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
